// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - control-flow resolver: condition flags, return-address stack, RUN/HALT/FAULT FSM
// Optional feature macro: BRANCH_CTRL_FLAG_BYPASS_EN (same-cycle ALU flags feed conditional branches)
module branch_ctrl #(
    parameter int RAS_DEPTH = 4,
    parameter int PC_W      = 8
) (
    input  logic            pb_clk_debounced,
    input  logic            rst_general,
    input  logic [PC_W-1:0] pc,
    input  logic            instr_valid,
    input  logic [3:0]      branch_op,
    input  logic [PC_W-1:0] offset,
    input  logic            flags_we,
    input  logic            alu_zero,
    input  logic            alu_neg,
    input  logic            alu_carry,
    output logic [7:0]      take_branch,
    output logic [PC_W-1:0] immediate,
    output logic [3:0]      ras_depth,
    output logic            halted,
    output logic            fault
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [3:0] OP_BEQ  = 4'd1;
    localparam logic [3:0] OP_BNE  = 4'd2;
    localparam logic [3:0] OP_BLT  = 4'd3;
    localparam logic [3:0] OP_BGE  = 4'd4;
    localparam logic [3:0] OP_BCS  = 4'd5;
    localparam logic [3:0] OP_JMP  = 4'd6;
    localparam logic [3:0] OP_CALL = 4'd7;
    localparam logic [3:0] OP_RET  = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd9;

    localparam logic [3:0] RAS_FULL = 4'(RAS_DEPTH);

    state_t          state_q, state_d;
    logic            z_q, z_d;
    logic            n_q, n_d;
    logic            c_q, c_d;
    logic [PC_W-1:0] ras_q [RAS_DEPTH];
    logic [PC_W-1:0] ras_d [RAS_DEPTH];
    logic [3:0]      ras_depth_q, ras_depth_d;
    logic            halted_q, halted_d;
    logic            fault_q, fault_d;

    logic            z_eff, n_eff, c_eff;
    logic            cond_taken;
    logic [PC_W-1:0] ras_top;
    logic            redirect;
    logic            stall;
    logic [PC_W-1:0] target_off;

`ifdef BRANCH_CTRL_FLAG_BYPASS_EN
    assign z_eff = flags_we ? alu_zero  : z_q;
    assign n_eff = flags_we ? alu_neg   : n_q;
    assign c_eff = flags_we ? alu_carry : c_q;
`else
    assign z_eff = z_q;
    assign n_eff = n_q;
    assign c_eff = c_q;
`endif

    always_comb begin
        cond_taken = 1'b0;
        case (branch_op)
            OP_BEQ:  cond_taken = z_eff;
            OP_BNE:  cond_taken = !z_eff;
            OP_BLT:  cond_taken = n_eff;
            OP_BGE:  cond_taken = !n_eff;
            OP_BCS:  cond_taken = c_eff;
            default: cond_taken = 1'b0;
        endcase
    end

    always_comb begin
        ras_top = '0;
        for (int i = 0; i < RAS_DEPTH; i++) begin
            if (4'(i + 1) == ras_depth_q) ras_top = ras_q[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        z_d         = z_q;
        n_d         = n_q;
        c_d         = c_q;
        ras_d       = ras_q;
        ras_depth_d = ras_depth_q;
        redirect    = 1'b0;
        stall       = 1'b0;
        target_off  = '0;

        if (flags_we && state_q != ST_FAULT) begin
            z_d = alu_zero;
            n_d = alu_neg;
            c_d = alu_carry;
        end

        if (state_q != ST_RUN || !instr_valid) begin
            stall = 1'b1;
        end else begin
            case (branch_op)
                OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BCS: begin
                    if (cond_taken) begin
                        redirect   = 1'b1;
                        target_off = offset;
                    end
                end
                OP_JMP: begin
                    redirect   = 1'b1;
                    target_off = offset;
                end
                OP_CALL: begin
                    if (ras_depth_q != RAS_FULL) begin
                        for (int i = 0; i < RAS_DEPTH; i++) begin
                            if (4'(i) == ras_depth_q) ras_d[i] = pc + PC_W'(1);
                        end
                        ras_depth_d = ras_depth_q + 4'd1;
                        redirect    = 1'b1;
                        target_off  = offset;
                    end else begin
                        stall   = 1'b1;
                        state_d = ST_FAULT;
                    end
                end
                OP_RET: begin
                    // Offset is chosen so that pc + immediate lands exactly on the popped address.
                    if (ras_depth_q != 4'd0) begin
                        ras_depth_d = ras_depth_q - 4'd1;
                        redirect    = 1'b1;
                        target_off  = ras_top - pc;
                    end else begin
                        stall   = 1'b1;
                        state_d = ST_FAULT;
                    end
                end
                OP_HALT: begin
                    stall   = 1'b1;
                    state_d = ST_HALT;
                end
                default: ;
            endcase
        end

        halted_d = (state_d == ST_HALT);
        fault_d  = (state_d == ST_FAULT);
    end

    always_comb begin
        take_branch = 8'h00;
        immediate   = '0;
        if (rst_general) begin
            take_branch = 8'h00;
            immediate   = '0;
        end else if (stall) begin
            take_branch = 8'h01;
            immediate   = '0;
        end else if (redirect) begin
            take_branch = 8'h01;
            immediate   = target_off;
        end
    end

    always_ff @(posedge pb_clk_debounced or posedge rst_general) begin
        if (rst_general) begin
            state_q     <= ST_RUN;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            ras_depth_q <= 4'd0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            z_q         <= z_d;
            n_q         <= n_d;
            c_q         <= c_d;
            ras_depth_q <= ras_depth_d;
            halted_q    <= halted_d;
            fault_q     <= fault_d;
            ras_q       <= ras_d;
        end
    end

    assign ras_depth = ras_depth_q;
    assign halted    = halted_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - randomized self-checking bench for branch_ctrl against a queue-based model
module tb_branch_ctrl;
    localparam int PC_W      = 8;
    localparam int RAS_DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [PC_W-1:0] pc = '0;
    logic            instr_valid = 1'b0;
    logic [3:0]      branch_op = '0;
    logic [PC_W-1:0] offset = '0;
    logic            flags_we = 1'b0;
    logic            alu_zero = 1'b0;
    logic            alu_neg = 1'b0;
    logic            alu_carry = 1'b0;
    logic [7:0]      take_branch;
    logic [PC_W-1:0] immediate;
    logic [3:0]      ras_depth;
    logic            halted;
    logic            fault;

    branch_ctrl #(.RAS_DEPTH(RAS_DEPTH), .PC_W(PC_W)) dut (
        .pb_clk_debounced(clk),
        .rst_general(rst),
        .pc(pc),
        .instr_valid(instr_valid),
        .branch_op(branch_op),
        .offset(offset),
        .flags_we(flags_we),
        .alu_zero(alu_zero),
        .alu_neg(alu_neg),
        .alu_carry(alu_carry),
        .take_branch(take_branch),
        .immediate(immediate),
        .ras_depth(ras_depth),
        .halted(halted),
        .fault(fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: 0 = running, 1 = halted, 2 = faulted
    int m_state = 0;
    bit mz = 0, mn = 0, mc = 0;
    int ras[$];

    task automatic model_reset();
        m_state = 0;
        mz = 0; mn = 0; mc = 0;
        ras.delete();
    endtask

    task automatic step(input int op, input int p, input int off, input bit v,
                        input bit fwe, input bit az, input bit an, input bit ac,
                        input string tag);
        bit fz, fn, fc, cond, stl, tk;
        int imm;
        branch_op = 4'(op); pc = PC_W'(p); offset = PC_W'(off); instr_valid = v;
        flags_we = fwe; alu_zero = az; alu_neg = an; alu_carry = ac;
        fz = mz; fn = mn; fc = mc;
`ifdef BRANCH_CTRL_FLAG_BYPASS_EN
        if (fwe) begin fz = az; fn = an; fc = ac; end
`endif
        stl = 0; tk = 0; imm = 0;
        if (m_state != 0 || !v) stl = 1;
        else begin
            case (op)
                1: cond = fz;
                2: cond = !fz;
                3: cond = fn;
                4: cond = !fn;
                5: cond = fc;
                default: cond = 0;
            endcase
            if (op >= 1 && op <= 5) begin tk = cond; imm = off; end
            else if (op == 6) begin tk = 1; imm = off; end
            else if (op == 7) begin
                if (ras.size() < RAS_DEPTH) begin tk = 1; imm = off; end else stl = 1;
            end else if (op == 8) begin
                if (ras.size() > 0) begin tk = 1; imm = (ras[$] - p) & 255; end else stl = 1;
            end else if (op == 9) stl = 1;
        end
        #1;
        chk({tag, "_take"}, take_branch, (stl || tk) ? 1 : 0);
        chk({tag, "_imm"}, immediate, (stl || !tk) ? 0 : (imm & 255));
        chk({tag, "_depth"}, ras_depth, ras.size());
        chk({tag, "_halted"}, halted, m_state == 1);
        chk({tag, "_fault"}, fault, m_state == 2);
        @(posedge clk);
        if (fwe && m_state != 2) begin mz = az; mn = an; mc = ac; end
        if (m_state == 0 && v) begin
            if (op == 7) begin
                if (ras.size() < RAS_DEPTH) ras.push_back((p + 1) & 255); else m_state = 2;
            end else if (op == 8) begin
                if (ras.size() > 0) void'(ras.pop_back()); else m_state = 2;
            end else if (op == 9) m_state = 1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, "_take"}, take_branch, 0);
        chk({tag, "_imm"}, immediate, 0);
        chk({tag, "_depth"}, ras_depth, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_fault"}, fault, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;

        step(0, 'h10, 0, 1, 0, 0, 0, 0, "reset_none");
        step(0, 'h11, 0, 1, 1, 1, 0, 0, "set_z");
        step(1, 'h20, 'hFC, 1, 0, 0, 0, 0, "beq_taken");
        step(2, 'h20, 'hFC, 1, 0, 0, 0, 0, "bne_not");
        step(0, 'h21, 0, 0, 0, 0, 0, 0, "invalid_stall");

        do_reset("rst1");
        step(7, 'h05, 'h10, 1, 0, 0, 0, 0, "call");
        step(8, 'h18, 0, 1, 0, 0, 0, 0, "ret");
        step(0, 'h06, 0, 1, 0, 0, 0, 0, "after_ret");

        do_reset("rst2");
        for (int i = 0; i < 5; i++) step(7, i * 3, 'h20, 1, 0, 0, 0, 0, "call_n");
        step(6, 'h30, 'h04, 1, 1, 1, 1, 1, "fault_jmp");
        step(1, 'h30, 'h04, 1, 0, 0, 0, 0, "fault_beq");

        do_reset("rst3");
        step(8, 'h40, 0, 1, 0, 0, 0, 0, "ret_empty");
        step(0, 'h41, 0, 1, 0, 0, 0, 0, "ret_empty_after");

        do_reset("rst4");
        step(7, 'hFF, 'h01, 1, 0, 0, 0, 0, "call_wrap");
        step(8, 'h40, 0, 1, 0, 0, 0, 0, "ret_wrap");
        step(9, 'h41, 0, 1, 0, 0, 0, 0, "halt");
        step(6, 'h41, 'h08, 1, 0, 0, 0, 0, "halted_jmp");
        step(7, 'h41, 'h08, 1, 1, 0, 1, 0, "halted_call");

        do_reset("rst5");
        step(1, 'h50, 'h07, 1, 1, 1, 0, 0, "bypass_beq");
        step(1, 'h50, 'h07, 1, 0, 0, 0, 0, "beq_after_we");

        // Reset asserted in the middle of a CALL cycle: no push may survive.
        do_reset("rst6");
        step(7, 'h60, 'h02, 1, 0, 0, 0, 0, "call_pre");
        branch_op = 4'd7; pc = 8'h62; offset = 8'h05; instr_valid = 1'b1;
        do_reset("rst_mid_call");
        step(0, 'h70, 0, 1, 0, 0, 0, 0, "after_mid_rst");

        for (int i = 0; i < 600; i++) begin
            int op;
            op = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 8) : $urandom_range(0, 15);
            step(op, $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 7) != 0, $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), "rnd");
            if (m_state != 0 && $urandom_range(0, 5) == 0) do_reset("rnd_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Control-flow resolver that drives the program counter's `take_branch` / `immediate` inputs and reads back the current `pc`.
- Holds the condition-flag register, a return-address stack (RAS) for CALL/RET, and a RUN/HALT/FAULT state machine.
- Every redirect is expressed as a PC-relative offset. The program counter's single adder (`pc + immediate`) therefore covers jumps, calls, returns and stalls.

Parameters:
- RAS_DEPTH, 4, number of return-address entries (2..8).
- PC_W, 8, PC and offset width; must match the program counter.

Ports:
- pb_clk_debounced  in  1  clock, rising edge.
- rst_general  in  1  reset, asynchronous, active-high.
- pc  in  PC_W  current PC from the program counter.
- instr_valid  in  1  current instruction fields are valid.
- branch_op  in  4  branch class of the current instruction.
- offset  in  PC_W  signed two's-complement branch/jump/call offset.
- flags_we  in  1  capture the ALU flags at this edge.
- alu_zero, alu_neg, alu_carry  in  1 each  ALU result flags.
- take_branch  out  8  8'h01 = add `immediate`, 8'h00 = increment by 1.
- immediate  out  PC_W  offset the program counter adds when `take_branch` is nonzero.
- ras_depth  out  4  number of valid stack entries.
- halted  out  1  state == HALT.
- fault  out  1  state == FAULT.

Behaviour:
- Reset values (async):
  - state RUN; flags Z/N/C = 0; RAS empty; `ras_depth` 0; `halted` 0; `fault` 0.
  - `take_branch` and `immediate` are forced to 0 while `rst_general` is high.
- `take_branch` and `immediate` are combinational from the current inputs plus registered state. The program counter consumes them on the same edge, so redirect latency is 0 cycles.
- All state updates (flags, RAS, state) occur on the rising edge.
- "Stall" means `take_branch` = 8'h01 and `immediate` = 0, which holds the PC.
- RUN state, `instr_valid` = 0: stall; no state change.
- RUN state, `instr_valid` = 1, by `branch_op`:
  - 0 NONE: `take_branch` = 0.
  - 1 BEQ: take if Z.
  - 2 BNE: take if !Z.
  - 3 BLT: take if N.
  - 4 BGE: take if !N.
  - 5 BCS: take if C.
  - Taken conditional branch: `immediate` = `offset`. Not taken: `take_branch` = 0, `immediate` = 0.
  - 6 JMP: always taken, `immediate` = `offset`.
  - 7 CALL, RAS not full:
    - push (`pc` + 1) mod 2^PC_W; `ras_depth`++.
    - taken, `immediate` = `offset`.
  - 7 CALL, RAS full: stall; no push; next state FAULT.
  - 8 RET, RAS not empty:
    - pop the top entry T; `ras_depth`--.
    - taken, `immediate` = (T − `pc`) mod 2^PC_W, so the next PC equals T exactly.
  - 8 RET, RAS empty: stall; next state FAULT.
  - 9 HALT: stall; next state HALT.
  - 10–15: treated as NONE.
- Flags:
  - Conditional branches evaluate the registered flags.
  - When `flags_we` = 1, Z/N/C capture `alu_zero` / `alu_neg` / `alu_carry` at the edge. This happens in any state except FAULT.
  - Same cycle `flags_we` and a conditional branch: the branch uses the old flags (bypass excepted, see Optional Feature).
- HALT state: stall every cycle; `halted` = 1; leaves only on reset.
- FAULT state: stall every cycle; `fault` = 1; RAS and flags are frozen; leaves only on reset.
- Offset and address arithmetic is modulo 2^PC_W:
  - a push at `pc` = 8'hFF stores 8'h00;
  - a negative `offset` (e.g. 8'hFE) means −2.
- Reset asserted mid-operation, e.g. during a CALL cycle: async clear, no push occurs, outputs go to 0 immediately.

Optional Feature:
- Macro BRANCH_CTRL_FLAG_BYPASS_EN.
- Defined: when `flags_we` = 1 in the same cycle as a conditional branch, the condition uses the incoming `alu_zero` / `alu_neg` / `alu_carry` rather than the registered flags. Flag register update is unchanged.
- Undefined: conditions always use the registered flags.

Test Plan:
- Reset then NONE: `pc` = 8'h10, `branch_op` = 0 → `take_branch` 0, `immediate` 0; `ras_depth` 0; `halted` 0; `fault` 0.
- Flags then branch: `flags_we` = 1 with `alu_zero` = 1; next cycle BEQ with `offset` 8'hFC at `pc` 8'h20 → `take_branch` 8'h01, `immediate` 8'hFC. Same setup with BNE → `take_branch` 0.
- CALL/RET round trip:
  - CALL at `pc` 8'h05, `offset` 8'h10 → `immediate` 8'h10, `ras_depth` 1.
  - RET at `pc` 8'h18 → `immediate` 8'hEE (next PC 8'h06), `ras_depth` 0.
- Stack bounds:
  - five CALLs with RAS_DEPTH 4 → fifth stalls and `fault` = 1; later ops all stall.
  - after reset, RET on an empty stack → `fault` = 1.
- Wrap and HALT:
  - CALL at `pc` 8'hFF pushes 8'h00; RET at `pc` 8'h40 → `immediate` 8'hC0.
  - HALT → `take_branch` 8'h01, `immediate` 0, `halted` = 1 until `rst_general` is pulsed.
- Bypass (macro defined vs undefined): `flags_we` = 1 with `alu_zero` = 1, plus BEQ in the same cycle, registered Z = 0 → taken only when BRANCH_CTRL_FLAG_BYPASS_EN is defined.
